// File: rtl/spu_point_loader_if.sv
// Bus bundle for the point loader. It carries the byte-wide command input
// stream and the registered segment operand output stream.
// The master side is the environment: it drives bytes in and takes frames out.
// The slave side is the loader itself.
interface spu_point_loader_if #(
  parameter int COORD_W = 4,
  parameter int OP_W    = 2
);
  logic [2*COORD_W-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [COORD_W-1:0]   out_a;
  logic [COORD_W-1:0]   out_b;
  logic [COORD_W-1:0]   out_c;
  logic [COORD_W-1:0]   out_d;
  logic [OP_W-1:0]      out_op;
  logic                 out_degen;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_a, out_b, out_c, out_d, out_op, out_degen, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_a, out_b, out_c, out_d, out_op, out_degen, out_valid
  );
endinterface

// File: rtl/spu_point_loader.sv
// Operand front-end for the spatial op stages. It collects a header byte and
// two point bytes, then presents them as registered segment operands
// (A,B)=P1 and (C,D)=P2 with the opcode under a valid/ready handshake.
// It also flags degenerate segments and counts completed output frames.
module spu_point_loader #(
  parameter int COORD_W = 4,
  parameter int OP_W    = 2,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  spu_point_loader_if.slave    bus,
  output logic                 hdr_err,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int BYTE_W = 2 * COORD_W;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {S_HDR, S_P1, S_P2, S_OUT} state_t;

  state_t               state_reg;
  logic [COORD_W-1:0]   a_reg, b_reg, c_reg, d_reg;
  logic [OP_W-1:0]      op_reg;
  logic                 degen_reg;
  logic                 valid_reg;
  logic                 hdr_err_reg;
  logic [CNT_W-1:0]     cnt_reg;

  logic [COORD_W-1:0]   in_x, in_y;
  logic                 hdr_bad;
  logic                 accept;
  logic                 in_ready_int;

  assign in_x    = bus.in_data[BYTE_W-1:COORD_W];
  assign in_y    = bus.in_data[COORD_W-1:0];
  // Any set bit above the opcode field makes the header unusable.
  assign hdr_bad = |bus.in_data[BYTE_W-1:OP_W];

  // Ready depends only on state and the reset/flush controls, so it never
  // forms a combinational loop through in_valid with the upstream producer.
  assign in_ready_int = !rst && !flush && (state_reg != S_OUT);
  assign accept       = bus.in_valid && in_ready_int;

  assign bus.in_ready  = in_ready_int;
  assign bus.out_a     = a_reg;
  assign bus.out_b     = b_reg;
  assign bus.out_c     = c_reg;
  assign bus.out_d     = d_reg;
  assign bus.out_op    = op_reg;
  assign bus.out_degen = degen_reg;
  assign bus.out_valid = valid_reg;
  assign hdr_err       = hdr_err_reg;
  assign frame_cnt     = cnt_reg;

  // Frame collection FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_HDR;
      a_reg       <= '0;
      b_reg       <= '0;
      c_reg       <= '0;
      d_reg       <= '0;
      op_reg      <= '0;
      degen_reg   <= 1'b0;
      valid_reg   <= 1'b0;
      hdr_err_reg <= 1'b0;
      cnt_reg     <= '0;
    end else if (flush) begin
      // Abandon the frame in progress. A transfer coinciding with the flush
      // is not counted.
      state_reg   <= S_HDR;
      valid_reg   <= 1'b0;
      hdr_err_reg <= 1'b0;
    end else begin
      hdr_err_reg <= 1'b0;
      case (state_reg)
        S_HDR: begin
          if (accept) begin
            if (hdr_bad) begin
              hdr_err_reg <= 1'b1;
            end else begin
              op_reg    <= bus.in_data[OP_W-1:0];
              state_reg <= S_P1;
            end
          end
        end
        S_P1: begin
          if (accept) begin
            a_reg     <= in_x;
            b_reg     <= in_y;
            state_reg <= S_P2;
          end
        end
        S_P2: begin
          if (accept) begin
            c_reg     <= in_x;
            d_reg     <= in_y;
            degen_reg <= (a_reg == in_x) && (b_reg == in_y);
            valid_reg <= 1'b1;
            state_reg <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            valid_reg <= 1'b0;
            cnt_reg   <= cnt_reg + CNT_ONE;
            state_reg <= S_HDR;
          end
        end
        default: state_reg <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_spu_point_loader.sv
// Testbench for spu_point_loader. Expected frames go to a scoreboard queue
// when their bytes are driven and are popped when the loader hands a frame
// out. Inputs change 1ns after the rising edge. Outputs are sampled on the
// falling edge.
module tb_spu_point_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       hdr_err;
  logic [7:0] frame_cnt;

  spu_point_loader_if #(.COORD_W(4), .OP_W(2)) bus ();

  spu_point_loader #(.COORD_W(4), .OP_W(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .hdr_err   (hdr_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] hdr;
    logic [7:0] p1;
    logic [7:0] p2;
    logic [1:0] op;
    logic [3:0] a, b, c, d;
    logic       degen;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_frames = 0;
  logic [18:0] exp_q[$];

  function automatic logic [18:0] pack(input logic [1:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c,
                                       input logic [3:0] d, input logic dg);
    return {op, a, b, c, d, dg};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: a frame leaves on out_valid & out_ready without flush.
  always @(negedge clk) begin
    logic [18:0] got;
    logic [18:0] req;
    if (!rst && !flush && bus.out_valid && bus.out_ready) begin
      got = {bus.out_op, bus.out_a, bus.out_b, bus.out_c, bus.out_d, bus.out_degen};
      if (exp_q.size() == 0) begin
        check("unexpected_frame", {13'd0, got}, 32'h7FFFFFFF);
      end else begin
        req = exp_q.pop_front();
        n_frames++;
        $display("frame %0d: op=%0d A=%0d B=%0d C=%0d D=%0d degen=%0d",
                 n_frames, bus.out_op, bus.out_a, bus.out_b, bus.out_c, bus.out_d, bus.out_degen);
        check("frame", {13'd0, got}, {13'd0, req});
      end
    end
  end

  // Called 1ns after a rising edge. Returns 1ns after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] p1, input logic [7:0] p2);
    send_byte(h);
    send_byte(p1);
    send_byte(p2);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    logic [7:0] h, p1, p2;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 2'd0, 4'd0,  4'd0,  4'd0,  4'd0,  1'b1};
    vecs[1] = '{8'h03, 8'hFF, 8'hFF, 2'd3, 4'd15, 4'd15, 4'd15, 4'd15, 1'b1};
    vecs[2] = '{8'h01, 8'h12, 8'h21, 2'd1, 4'd1,  4'd2,  4'd2,  4'd1,  1'b0};
    vecs[3] = '{8'h02, 8'hA5, 8'hA6, 2'd2, 4'd10, 4'd5,  4'd10, 4'd6,  1'b0};
    vecs[4] = '{8'h00, 8'h5C, 8'h6C, 2'd0, 4'd5,  4'd12, 4'd6,  4'd12, 1'b0};
    vecs[5] = '{8'h03, 8'h80, 8'h08, 2'd3, 4'd8,  4'd0,  4'd0,  4'd8,  1'b0};

    rst = 1'b1;
    flush = 1'b0;
    bus.in_data = 8'h00;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_hdr_err", hdr_err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_outputs", pack(bus.out_op, bus.out_a, bus.out_b, bus.out_c, bus.out_d, bus.out_degen), 0);
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    step();

    // Happy path.
    bus.out_ready = 1'b1;
    exp_q.push_back(pack(2'd1, 4'd3, 4'd5, 4'd7, 4'd5, 1'b0));
    send_frame(8'h01, 8'h35, 8'h75);
    @(negedge clk);
    check("latency_out_valid", bus.out_valid, 1);
    drain();
    @(negedge clk);
    check("happy_cnt", frame_cnt, 1);
    check("happy_valid_low", bus.out_valid, 0);
    step();

    // Backpressure: outputs held and input blocked while out_ready is low.
    bus.out_ready = 1'b0;
    exp_q.push_back(pack(2'd1, 4'd3, 4'd5, 4'd7, 4'd5, 1'b0));
    send_frame(8'h01, 8'h35, 8'h75);
    bus.in_valid = 1'b1;
    bus.in_data = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_hold", pack(bus.out_op, bus.out_a, bus.out_b, bus.out_c, bus.out_d, bus.out_degen),
            pack(2'd1, 4'd3, 4'd5, 4'd7, 4'd5, 1'b0));
      step();
    end
    bus.in_valid = 1'b0;
    check("bp_cnt_held", frame_cnt, 1);
    bus.out_ready = 1'b1;
    step();
    @(negedge clk);
    check("bp_in_ready_after", bus.in_ready, 1);
    check("bp_cnt", frame_cnt, 2);
    check("bp_scoreboard", exp_q.size(), 0);
    step();

    // Bad header, then a degenerate frame.
    send_byte(8'h41);
    @(negedge clk);
    check("bad_hdr_pulse", hdr_err, 1);
    check("bad_hdr_stay", bus.in_ready, 1);
    step();
    @(negedge clk);
    check("bad_hdr_clear", hdr_err, 0);
    step();
    exp_q.push_back(pack(2'd2, 4'd2, 4'd2, 4'd2, 4'd2, 1'b1));
    send_frame(8'h02, 8'h22, 8'h22);
    drain();

    // Two bad headers back to back give two consecutive pulses.
    bus.in_data = 8'h41;
    bus.in_valid = 1'b1;
    step();
    bus.in_data = 8'h80;
    @(negedge clk);
    check("bad2_first", hdr_err, 1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bad2_second", hdr_err, 1);
    step();
    @(negedge clk);
    check("bad2_end", hdr_err, 0);
    step();

    // Gapped input, then flush discards the partial P1.
    send_byte(8'h00);
    send_byte(8'h11);
    repeat (3) step();
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h99;
    @(negedge clk);
    check("flush_in_ready", bus.in_ready, 0);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.push_back(pack(2'd3, 4'd15, 4'd0, 4'd0, 4'd15, 1'b0));
    send_frame(8'h03, 8'hF0, 8'h0F);
    drain();
    @(negedge clk);
    check("flush_cnt", frame_cnt, 4);
    step();

    // Flush coinciding with a transfer: the frame is dropped and not counted.
    bus.out_ready = 1'b0;
    send_frame(8'h01, 8'h11, 8'h22);
    @(negedge clk);
    check("fx_valid", bus.out_valid, 1);
    step();
    bus.out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("fx_valid_low", bus.out_valid, 0);
    check("fx_cnt", frame_cnt, 4);
    step();

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(pack(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].degen));
      send_frame(vecs[i].hdr, vecs[i].p1, vecs[i].p2);
    end
    drain();
    @(negedge clk);
    check("table_cnt", frame_cnt, 10);
    step();

    // Random frames up to 256 completions; the counter wraps to zero.
    for (int i = 0; i < 246; i++) begin
      h  = 8'($urandom_range(0, 3));
      p1 = 8'($urandom_range(0, 255));
      p2 = ($urandom_range(0, 3) == 0) ? p1 : 8'($urandom_range(0, 255));
      exp_q.push_back(pack(h[1:0], p1[7:4], p1[3:0], p2[7:4], p2[3:0], p1 == p2));
      send_frame(h, p1, p2);
    end
    drain();
    @(negedge clk);
    check("wrap_cnt", frame_cnt, 0);
    step();

    // Reset while waiting for P2.
    send_byte(8'h01);
    send_byte(8'h34);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", bus.in_ready, 0);
    step();
    @(negedge clk);
    check("mid_rst_outputs", pack(bus.out_op, bus.out_a, bus.out_b, bus.out_c, bus.out_d, bus.out_degen), 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_in_ready2", bus.in_ready, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_after", bus.in_ready, 1);
    step();
    exp_q.push_back(pack(2'd2, 4'd7, 4'd7, 4'd7, 4'd7, 1'b1));
    send_frame(8'h02, 8'h77, 8'h77);
    drain();
    @(negedge clk);
    check("post_rst_cnt", frame_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
